// File: rtl/weight_fetch_ctrl.sv
// weight_fetch_ctrl: streams kernel_cnt*DEPTH weight words from SRAM into
// the weight FIFO, hiding SRAM read latency and FIFO backpressure.
//
// Ports:
//   clk, rst_n             clock / async active-low reset
//   start                  1-cycle job request (ignored while busy)
//   base_addr, kernel_cnt  job parameters, sampled with start
//   busy, done             job status; done is a 1-cycle pulse
//   mem_rd_en, mem_addr    SRAM read request
//   mem_rd_data            SRAM read data, valid one cycle after mem_rd_en
//   i_valid, i_data        FIFO write port
//   full                   FIFO full; a word moves when i_valid && !full
module weight_fetch_ctrl #(
    parameter int DW    = 32,
    parameter int DEPTH = 9,
    parameter int AW    = 16,
    parameter int KW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [KW-1:0] kernel_cnt,
    output logic          busy,
    output logic          done,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_rd_data,
    output logic          i_valid,
    output logic [DW-1:0] i_data,
    input  logic          full
);

    localparam int TW = KW + 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q;
    logic [TW-1:0] remain_q;
    logic          inflight_q;
    logic [1:0]    occ_q;
    logic [DW-1:0] buf0_q, buf1_q;

    logic          pop;
    logic          push;
    logic [2:0]    credit;
    logic          rd_go;

    assign pop  = (occ_q != 2'd0) && !full;
    assign push = inflight_q;

    // Words held or on their way, minus the one leaving this cycle.
    assign credit = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign rd_go  = (state_q == S_FETCH) && (remain_q != '0)
                    && (credit < 3'd2);

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (kernel_cnt != '0) ? S_FETCH : S_DONE;
                end
            end
            S_FETCH: begin
                if (rd_go && (remain_q == TW'(1))) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if ((occ_q == 2'd0) && !inflight_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        mem_rd_en = rd_go;
    end

    assign mem_addr = addr_q;
    assign i_valid  = (occ_q != 2'd0);
    assign i_data   = buf0_q;

    // ---------------- read address / count ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            remain_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= rd_go;
            if ((state_q == S_IDLE) && start) begin
                addr_q   <= base_addr;
                remain_q <= {4'b0000, kernel_cnt} * TW'(DEPTH);
            end else if (rd_go) begin
                addr_q   <= addr_q + AW'(1);
                remain_q <= remain_q - TW'(1);
            end
        end
    end

    // ---------------- 2-entry skid buffer ----------------
    // buf0_q is always the head; buf1_q only holds data when occ_q == 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q  <= 2'd0;
            buf0_q <= '0;
            buf1_q <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ_q == 2'd0) begin
                        buf0_q <= mem_rd_data;
                    end else begin
                        buf1_q <= mem_rd_data;
                    end
                    occ_q <= occ_q + 2'd1;
                end
                2'b01: begin
                    buf0_q <= buf1_q;
                    occ_q  <= occ_q - 2'd1;
                end
                2'b11: begin
                    if (occ_q == 2'd1) begin
                        buf0_q <= mem_rd_data;
                    end else begin
                        buf0_q <= buf1_q;
                        buf1_q <= mem_rd_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// tb_weight_fetch_ctrl: table-driven and randomized jobs checked against
// a word-order scoreboard and an SRAM model.
module tb_weight_fetch_ctrl;

    localparam int DW    = 32;
    localparam int DEPTH = 9;
    localparam int AW    = 16;
    localparam int KW    = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [KW-1:0] kernel_cnt = '0;
    logic          busy;
    logic          done;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rd_data = '0;
    logic          i_valid;
    logic [DW-1:0] i_data;
    logic          full = 1'b0;

    int checks = 0;
    int passes = 0;

    weight_fetch_ctrl #(
        .DW(DW), .DEPTH(DEPTH), .AW(AW), .KW(KW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .kernel_cnt (kernel_cnt),
        .busy       (busy),
        .done       (done),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rd_data(mem_rd_data),
        .i_valid    (i_valid),
        .i_data     (i_data),
        .full       (full)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] memval(input logic [AW-1:0] a);
        return {~a, a} ^ 32'h0F0F_0000;
    endfunction

    // SRAM model with one cycle of read latency
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= memval(mem_addr);
    end

    task automatic chk(input string name, input longint act,
                       input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic [AW-1:0] base;
        int            k;
        int            mode;
        int            exp_done;
        bit            restart;
    } vec_t;

    function automatic logic pick_full(input int mode, input int n);
        case (mode)
            1:       return logic'(n % 2);
            2:       return logic'($urandom_range(0, 1));
            3:       return (n >= 6) && (n < 26);
            default: return 1'b0;
        endcase
    endfunction

    task automatic run_job(input vec_t v);
        int total;
        int reads;
        int acc;
        int n;
        int first_rd;
        int first_v;
        int busy_drop;
        bit fin;
        bit held;
        bit pop;
        logic [DW-1:0] held_d;
        total = v.k * DEPTH;
        reads = 0; acc = 0; first_rd = -1; first_v = -1;
        busy_drop = 0; fin = 0; held = 0; held_d = '0;
        @(posedge clk); #1;
        base_addr = v.base; kernel_cnt = KW'(v.k); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        base_addr = AW'($urandom); kernel_cnt = KW'($urandom);
        n = 1;
        full = pick_full(v.mode, n);
        while (!fin && n < 3000) begin
            @(negedge clk);
            pop = i_valid && !full;
            if (held) begin
                chk("stable_valid", longint'(i_valid), 1);
                chk("stable_data", longint'(i_data), longint'(held_d));
            end
            if (mem_rd_en) begin
                if (first_rd < 0) first_rd = n;
                chk("rd_addr", longint'(mem_addr),
                    longint'(AW'(v.base + AW'(reads))));
                chk("credit", longint'((reads - acc - int'(pop)) < 2), 1);
                chk("rd_excess", longint'(reads < total), 1);
                reads++;
            end
            if (i_valid && first_v < 0) first_v = n;
            if (pop) begin
                chk("word", longint'(i_data),
                    longint'(memval(AW'(v.base + AW'(acc)))));
                acc++;
            end
            held = i_valid && full;
            held_d = i_data;
            if (!busy) busy_drop++;
            if (done) begin
                fin = 1;
            end else begin
                @(posedge clk); #1;
                n++;
                full = pick_full(v.mode, n);
                if (v.restart && n == 5) begin
                    start = 1'b1; kernel_cnt = 8'd2;
                    base_addr = v.base ^ 16'h5555;
                end else begin
                    start = 1'b0;
                end
            end
        end
        chk("timeout", longint'(fin), 1);
        chk("reads", reads, total);
        chk("accepted", acc, total);
        chk("busy_held", busy_drop, 0);
        if (v.exp_done > 0) chk("done_cycle", n, v.exp_done);
        if (v.mode == 0 && v.k > 0) begin
            chk("first_rd", first_rd, 1);
            chk("first_valid", first_v, 3);
        end
        @(posedge clk); #1;
        full = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("idle_busy", longint'(busy), 0);
        chk("done_pulse", longint'(done), 0);
    endtask

    task automatic abort_test();
        int acc;
        int n;
        int done_seen;
        acc = 0; n = 0; done_seen = 0;
        @(posedge clk); #1;
        base_addr = 16'h0200; kernel_cnt = 8'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (acc < 5 && n < 100) begin
            @(negedge clk);
            if (i_valid && !full) acc++;
            n++;
        end
        chk("abort_reach", acc, 5);
        rst_n = 1'b0;
        #1;
        chk("rst_busy", longint'(busy), 0);
        chk("rst_rd_en", longint'(mem_rd_en), 0);
        chk("rst_valid", longint'(i_valid), 0);
        chk("rst_data", longint'(i_data), 0);
        chk("rst_addr", longint'(mem_addr), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done || busy || i_valid || mem_rd_en) done_seen++;
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        chk("abort_quiet", done_seen, 0);
        run_job('{base: 16'h03A0, k: 2, mode: 0, exp_done: 22, restart: 0});
    endtask

    vec_t tbl[7];

    initial begin
        vec_t rv;
        tbl[0] = '{base: 16'h0100, k: 1, mode: 0, exp_done: 13, restart: 0};
        tbl[1] = '{base: 16'h0040, k: 3, mode: 1, exp_done: 0,  restart: 0};
        tbl[2] = '{base: 16'h0500, k: 2, mode: 3, exp_done: 0,  restart: 0};
        tbl[3] = '{base: 16'hFFFC, k: 1, mode: 0, exp_done: 13, restart: 0};
        tbl[4] = '{base: 16'h0000, k: 0, mode: 0, exp_done: 1,  restart: 0};
        tbl[5] = '{base: 16'h0777, k: 2, mode: 0, exp_done: 22, restart: 1};
        tbl[6] = '{base: 16'h1234, k: 3, mode: 2, exp_done: 0,  restart: 0};

        #12;
        chk("reset_busy", longint'(busy), 0);
        chk("reset_done", longint'(done), 0);
        chk("reset_rd_en", longint'(mem_rd_en), 0);
        chk("reset_valid", longint'(i_valid), 0);
        chk("reset_addr", longint'(mem_addr), 0);
        chk("reset_data", longint'(i_data), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_job(tbl[i]);

        for (int i = 0; i < 6; i++) begin
            rv.base = AW'($urandom);
            rv.k = int'($urandom_range(0, 4));
            rv.mode = int'($urandom_range(0, 3));
            rv.restart = 0;
            if (rv.mode == 0) rv.exp_done = (rv.k == 0) ? 1 : rv.k * DEPTH + 4;
            else rv.exp_done = 0;
            run_job(rv);
        end

        abort_test();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
